// File: rtl/gups_mem_responder_pkg.sv
// gups_pkg: shared bus widths and FSM encoding for the gups memory responder
package gups_pkg;
  localparam int GUPS_DATA_W = 64;
  localparam int GUPS_ADDR_W = 64;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;
endpackage

// File: rtl/gups_mem_responder_if.sv
// gups_mem_responder_if: gups req/wr/rdy request bus between initiator and memory
interface gups_mem_responder_if;
  import gups_pkg::*;
  logic                   req;
  logic                   wr;
  logic [GUPS_ADDR_W-1:0] addr;
  logic [GUPS_DATA_W-1:0] dout;
  logic [GUPS_DATA_W-1:0] din;
  logic                   rdy;
  modport master (output req, wr, addr, dout, input din, rdy);
  modport slave (input req, wr, addr, dout, output din, rdy);
endinterface

// File: rtl/gups_mem_responder_ram.sv
// gups_mem_ram: single-port sync RAM, one read-or-write per cycle, registered read
module gups_mem_ram #(
  parameter int AW = 13,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_a,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_a] <= i_d;
    else if (i_en) o_q <= r_mem[i_a];
  end
endmodule

// File: rtl/gups_mem_responder.sv
// gups_mem_responder: latency-programmable memory responder for the gups bus.
// GUPS_MEM_RANGE_CHK_EN adds err and suppresses accesses above the RAM depth.
module gups_mem_responder
  import gups_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 5,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  gups_mem_responder_if.slave bus,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt
`ifdef GUPS_MEM_RANGE_CHK_EN
  ,output logic              err
`endif
);
  localparam int MAX_LAT = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int LW = $clog2(MAX_LAT) + 1;
  state_t r_state, w_next;
  logic [LW-1:0] r_cnt, w_lat;
  logic [ADDR_BITS-1:0] r_addr, w_ram_a;
  logic [GUPS_DATA_W-1:0] r_dout, r_din, w_q;
  logic r_wr, r_ok, w_ok, w_ack, w_re, w_we;
`ifdef GUPS_MEM_RANGE_CHK_EN
  assign w_ok = bus.addr[GUPS_ADDR_W-1:ADDR_BITS] == '0;
  assign err = w_ack && !r_ok;
`else
  logic w_unused_hi;
  assign w_ok = 1'b1;
  assign w_unused_hi = |bus.addr[GUPS_ADDR_W-1:ADDR_BITS];
`endif
  // the RAM read is launched on the edge entering ACK so its data is ready in the rdy cycle
  always_comb begin
    w_lat = bus.wr ? LW'(WR_LAT - 1) : LW'(RD_LAT - 1);
    w_next = r_state == ST_IDLE ? (bus.req ? (w_lat == '0 ? ST_ACK : ST_BUSY) : ST_IDLE)
           : r_state == ST_BUSY ? (r_cnt == LW'(1) ? ST_ACK : ST_BUSY) : ST_IDLE;
    w_ack = r_state == ST_ACK;
    w_ram_a = r_state == ST_IDLE ? bus.addr[ADDR_BITS-1:0] : r_addr;
    w_re = !w_ack && w_next == ST_ACK && !(r_state == ST_IDLE ? bus.wr : r_wr);
    w_we = w_ack && r_wr && r_ok && !rst;
    bus.din = w_ack && !r_wr ? (r_ok ? w_q : '0) : r_din;
    bus.rdy = w_ack;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_din <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_state == ST_IDLE ? w_lat : r_cnt - LW'(1);
      if (r_state == ST_IDLE && bus.req) begin
        r_wr <= bus.wr;
        r_addr <= bus.addr[ADDR_BITS-1:0];
        r_dout <= bus.dout;
        r_ok <= w_ok;
      end
      if (w_ack) begin
        r_din <= bus.din;
        rd_cnt <= rd_cnt + CNT_W'(!r_wr);
        wr_cnt <= wr_cnt + CNT_W'(r_wr);
      end
    end
  end
  gups_mem_ram #(.AW(ADDR_BITS), .DW(GUPS_DATA_W)) u_ram (
    .clk  (clk),
    .i_en (w_re),
    .i_we (w_we),
    .i_a  (w_ram_a),
    .i_d  (r_dout),
    .o_q  (w_q)
  );
endmodule

// File: tb/tb_gups_mem_responder.sv
// tb_gups_mem_responder: directed checks of latency, data, counters, reset abort, range handling
module tb_gups_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rd_cnt, wr_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [63:0] q;
  int n;
  logic e;
  logic [63:0] b_a [3];
  logic [63:0] b_d [3];
`ifdef GUPS_MEM_RANGE_CHK_EN
  logic err;
`endif
  gups_mem_responder_if bus();
  gups_mem_responder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
`ifdef GUPS_MEM_RANGE_CHK_EN
    ,.err   (err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rq, output int lat, output logic re);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.dout = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rdy && lat < 20);
    rq = bus.din;
`ifdef GUPS_MEM_RANGE_CHK_EN
    re = err;
`else
    re = 1'b0;
`endif
    bus.req = 1'b0;
    if (w) exp_wr++; else exp_rd++;
    @(negedge clk);
    chk("rdy_one_cycle", {63'd0, bus.rdy}, 64'd0);
  endtask
  task automatic wr_word(input logic [63:0] a, input logic [63:0] d);
    xfer(1'b1, a, d, q, n, e);
    chk("wr_lat", 64'(n), 64'd5);
  endtask
  task automatic rd_word(input string tag, input logic [63:0] a, input logic [63:0] d);
    xfer(1'b0, a, 64'd0, q, n, e);
    chk("rd_lat", 64'(n), 64'd2);
    chk(tag, q, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, last, seen;
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = '0; bus.dout = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy", {63'd0, bus.rdy}, 64'd0);
    end
    chk("rst_din", bus.din, 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    bus.req = 1'b0;
    rst = 1'b0;
    wr_word(64'd5, 64'hDEAD_BEEF_0000_0001);
    rd_word("rd_addr5", 64'd5, 64'hDEAD_BEEF_0000_0001);
    wr_word(64'h1FFF, 64'h10);
    rd_word("rmw_read", 64'h1FFF, 64'h10);
    wr_word(64'h1FFF, 64'h11);
    rd_word("rmw_reread", 64'h1FFF, 64'h11);
    chk("rd_cnt", 64'(rd_cnt), 64'(exp_rd));
    chk("wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    wr_word(64'd7, 64'hAAAA_5555_0000_0007);
    b_a[0] = 64'd5;    b_d[0] = 64'hDEAD_BEEF_0000_0001;
    b_a[1] = 64'd7;    b_d[1] = 64'hAAAA_5555_0000_0007;
    b_a[2] = 64'h1FFF; b_d[2] = 64'h11;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = b_a[0];
    k = 0; last = 0;
    for (int c = 1; c <= 15 && k < 3; c++) begin
      @(negedge clk);
      if (bus.rdy) begin
        chk("b2b_gap", 64'(c - last), k == 0 ? 64'd2 : 64'd3);
        chk("b2b_din", bus.din, b_d[k]);
        k++;
        last = c;
        if (k < 3) bus.addr = b_a[k];
      end
    end
    bus.req = 1'b0;
    exp_rd += 3;
    chk("b2b_pulses", 64'(k), 64'd3);
    @(negedge clk);
    chk("b2b_rd_cnt", 64'(rd_cnt), 64'(exp_rd));
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 64'd7; bus.dout = 64'hBAD;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(bus.rdy);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(bus.rdy);
    end
    chk("abort_no_rdy", 64'(seen), 64'd0);
    exp_rd = 0; exp_wr = 0;
    chk("abort_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("abort_din", bus.din, 64'd0);
    rd_word("abort_addr7", 64'd7, 64'hAAAA_5555_0000_0007);
    wr_word(64'd0, 64'h55);
    xfer(1'b1, 64'h2000, 64'h1, q, n, e);
    chk("range_wr_lat", 64'(n), 64'd5);
`ifdef GUPS_MEM_RANGE_CHK_EN
    chk("range_err", {63'd0, e}, 64'd1);
    rd_word("range_addr0", 64'd0, 64'h55);
    rd_word("range_rd_hi", 64'h2000, 64'd0);
    chk("range_err_rd", {63'd0, e}, 64'd1);
    rd_word("range_rd_ok", 64'd5, 64'hDEAD_BEEF_0000_0001);
    chk("range_no_err", {63'd0, e}, 64'd0);
`else
    rd_word("wrap_addr0", 64'd0, 64'h1);
    rd_word("wrap_rd_hi", 64'h2000, 64'h1);
`endif
    chk("final_rd_cnt", 64'(rd_cnt), 64'(exp_rd));
    chk("final_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
